menu_nav_ctrl: RTL

Clean-clock replacement for the ATM menu's button-driven selection logic. Conditions the raw BTNU/BTND/BTNC/BTNL push-buttons (synchronise, debounce, edge-detect) and holds the selected menu index with wrap-around. It drives the per-item active-high resets feeding the instruction scrollers (balance, withdraw, currency, transfer). It also runs the start/done/abort handshake into the selected transaction block; everything is on clk, with no button-derived clocks.

---
 rtl/menu_nav_pkg.sv | 17 +
 rtl/menu_nav_if.sv | 29 ++
 rtl/menu_nav_ctrl_btn.sv | 53 +++++
 rtl/menu_nav_ctrl.sv | 108 ++++++++++
 4 files changed

// File: rtl/menu_nav_pkg.sv
// Shared types and constants for the ATM menu navigation controller.
// Item indices match the order of the instruction scrollers.
package menu_nav_pkg;

    typedef enum logic [1:0] {
        BROWSE = 2'd0,
        LAUNCH = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam int IDX_BALANCE   = 0;
    localparam int IDX_WITHDRAW  = 1;
    localparam int IDX_CURRENCY  = 2;
    localparam int IDX_TRANSFER  = 3;
    localparam int DEF_NUM_ITEMS = 4;

endpackage

// File: rtl/menu_nav_if.sv
// Button inputs, selection outputs and transaction handshake of the menu.
// The master side is the controller; the slave side is its environment.
interface menu_nav_if
    import menu_nav_pkg::*;
#(
    parameter int NUM_ITEMS = DEF_NUM_ITEMS,
    parameter int IDX_W     = 2
);
    logic                 btn_up;
    logic                 btn_down;
    logic                 btn_sel;
    logic                 btn_back;
    logic                 op_done;
    logic [IDX_W-1:0]     sel_idx;
    logic [NUM_ITEMS-1:0] item_rst;
    logic                 op_start;
    logic                 op_abort;
    logic                 busy;

    modport master (
        input  btn_up, btn_down, btn_sel, btn_back, op_done,
        output sel_idx, item_rst, op_start, op_abort, busy
    );

    modport slave (
        output btn_up, btn_down, btn_sel, btn_back, op_done,
        input  sel_idx, item_rst, op_start, op_abort, busy
    );
endinterface

// File: rtl/menu_nav_ctrl_btn.sv
// Push-button conditioner: 2-flop synchroniser, debounce counter and
// a single-cycle pulse on each accepted press.
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic pulse_o
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s2_q;
    logic             lvl_q, lvl_d;
    logic             prev_q, rise_q, pulse_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        lvl_d = lvl_q;
        cnt_d = '0;
        if (s2_q != lvl_q) begin
            if (cnt_q == CNT_LAST) begin
                lvl_d = ~lvl_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Edge flag plus output stage keeps the pulse fully registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            lvl_q   <= 1'b0;
            cnt_q   <= '0;
            prev_q  <= 1'b0;
            rise_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            s1_q    <= btn_i;
            s2_q    <= s1_q;
            lvl_q   <= lvl_d;
            cnt_q   <= cnt_d;
            prev_q  <= lvl_q;
            rise_q  <= lvl_q & ~prev_q;
            pulse_q <= rise_q;
        end
    end

    assign pulse_o = pulse_q;
endmodule

// File: rtl/menu_nav_ctrl.sv
// Menu selection FSM: index with wrap-around, idle return to the first
// item, per-item scroller resets and the start/done/abort handshake.
module menu_nav_ctrl
    import menu_nav_pkg::*;
#(
    parameter int              NUM_ITEMS       = DEF_NUM_ITEMS,
    parameter int              IDX_W           = 2,
    parameter int              DEBOUNCE_CYCLES = 1000000,
    parameter longint unsigned IDLE_CYCLES     = 64'd3000000000
) (
    input logic        clk,
    input logic        rst,
    menu_nav_if.master bus
);
    localparam bit IDLE_EN = (IDLE_CYCLES != 0);
    localparam int IDLE_W  = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
    localparam logic [IDLE_W-1:0]    IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
    localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(NUM_ITEMS - 1);
    localparam logic [IDX_W-1:0]     IDX_HOME  = IDX_W'(IDX_BALANCE);
    localparam logic [NUM_ITEMS-1:0] IRST_RST  = ~(NUM_ITEMS'(1) << IDX_HOME);

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      sel_q, sel_d;
    logic [IDLE_W-1:0]     idle_q, idle_d;
    logic [NUM_ITEMS-1:0]  irst_q, irst_d;
    logic up_p, dn_p, sel_p, back_p, any_p;
    logic op_start, op_abort, busy;

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
        .clk(clk), .rst(rst), .btn_i(bus.btn_up), .pulse_o(up_p));
    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dn (
        .clk(clk), .rst(rst), .btn_i(bus.btn_down), .pulse_o(dn_p));
    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sel (
        .clk(clk), .rst(rst), .btn_i(bus.btn_sel), .pulse_o(sel_p));
    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_back (
        .clk(clk), .rst(rst), .btn_i(bus.btn_back), .pulse_o(back_p));

    assign any_p  = up_p | dn_p | sel_p | back_p;
    assign irst_d = ~(NUM_ITEMS'(1) << sel_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BROWSE;
            sel_q   <= IDX_HOME;
            idle_q  <= '0;
            irst_q  <= IRST_RST;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            idle_q  <= idle_d;
            irst_q  <= irst_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        idle_d  = '0;
        unique case (state_q)
            BROWSE: begin
                if (!any_p && IDLE_EN) begin
                    if (idle_q == IDLE_LAST) begin
                        sel_d = IDX_HOME;
                    end else begin
                        idle_d = idle_q + IDLE_W'(1);
                    end
                end
                if (sel_p) begin
                    state_d = LAUNCH;
                end else if (up_p && !dn_p) begin
                    sel_d = (sel_q == '0) ? IDX_LAST : sel_q - IDX_W'(1);
                end else if (dn_p && !up_p) begin
                    sel_d = (sel_q == IDX_LAST) ? '0 : sel_q + IDX_W'(1);
                end
            end
            LAUNCH: state_d = ACTIVE;
            ACTIVE: begin
                if (bus.op_done || back_p) state_d = BROWSE;
            end
            default: state_d = BROWSE;
        endcase
    end

    // Abort is suppressed when the transaction finishes in the same cycle.
    always_comb begin
        op_start = 1'b0;
        op_abort = 1'b0;
        busy     = 1'b0;
        unique case (state_q)
            BROWSE: ;
            LAUNCH: begin
                op_start = 1'b1;
                busy     = 1'b1;
            end
            ACTIVE: begin
                busy     = 1'b1;
                op_abort = back_p & ~bus.op_done;
            end
            default: ;
        endcase
    end

    assign bus.sel_idx  = sel_q;
    assign bus.item_rst = irst_q;
    assign bus.op_start = op_start;
    assign bus.op_abort = op_abort;
    assign bus.busy     = busy;
endmodule
